// File: rtl/mux4_rr_tx_pkg.sv
// Shared constants, select encodings and state type for the 4-way round-robin
// transmit multiplexer and its arbiter.
package mux4_rr_tx_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef logic [SEL_W-1:0] sel_t;

   // Select codes; the receiving demux routes CHn to its output dn.
   localparam sel_t CH0 = 2'b00;
   localparam sel_t CH1 = 2'b01;
   localparam sel_t CH2 = 2'b10;
   localparam sel_t CH3 = 2'b11;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } fsm_state_t;

   function automatic logic [NUM_CH-1:0] sel_onehot(input sel_t sel);
      logic [NUM_CH-1:0] oh;
      oh = '0;
      case (sel)
         CH0:     oh = 4'b0001;
         CH1:     oh = 4'b0010;
         CH2:     oh = 4'b0100;
         CH3:     oh = 4'b1000;
         default: oh = '0;
      endcase
      return oh;
   endfunction

   // 2-bit increment, wraps 3 -> 0.
   function automatic sel_t sel_next(input sel_t sel);
      return sel + sel_t'(1);
   endfunction

endpackage

// File: rtl/mux4_rr_tx_if.sv
// Bundle of the four producer handshakes and the merged output stream.
// Handshake rule: a word moves in any cycle where its valid and ready are both 1.
interface mux4_rr_tx_if #(
   parameter int WIDTH = 8
);
   import mux4_rr_tx_pkg::*;

   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_ready;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   sel_t                    out_sel;
   logic                    out_ready;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sel
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sel
   );

endinterface

// File: rtl/mux4_rr_tx_rr_arbiter4.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// When nothing requests, grant reflects ptr and any is low.
module rr_arbiter4
   import mux4_rr_tx_pkg::*;
(
   input  sel_t              ptr,
   input  logic [NUM_CH-1:0] req,
   output sel_t              grant,
   output logic              any
);

   assign any = |req;

   // Scan from the farthest candidate back to ptr so the nearest one wins.
   always_comb begin
      sel_t idx;
      grant = ptr;
      idx   = ptr;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = ptr + sel_t'(k);
         if (req[idx]) begin
            grant = idx;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_tx.sv
// 4-to-1 round-robin transmit mux: one output register tagged with its source
// channel, refilled in the same cycle it drains so throughput stays 1 word/cycle.
module mux4_rr_tx
   import mux4_rr_tx_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   mux4_rr_tx_if.slave bus,
   output fsm_state_t state_dbg
);

   fsm_state_t        state_q;
   fsm_state_t        state_n;
   sel_t              ptr_q;
   sel_t              grant;
   logic              any;
   logic              load;
   logic [NUM_CH-1:0] ready;
   logic [WIDTH-1:0]  data_q;
   sel_t              sel_q;
   logic [WIDTH-1:0]  words [NUM_CH];

   rr_arbiter4 u_arb (
      .ptr   (ptr_q),
      .req   (bus.in_valid),
      .grant (grant),
      .any   (any)
   );

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         words[i] = bus.in_data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_n;
      end
   end

   // in_ready depends only on valids, pointer, occupancy and out_ready.
   always_comb begin
      state_n = state_q;
      load    = 1'b0;
      ready   = '0;
      case (state_q)
         ST_EMPTY: begin
            load = any & ~rst;
            if (load) begin
               state_n = ST_FULL;
            end
         end
         ST_FULL: begin
            load = bus.out_ready & any & ~rst;
            if (bus.out_ready && !load) begin
               state_n = ST_EMPTY;
            end
         end
         default: begin
            state_n = ST_EMPTY;
         end
      endcase
      if (load) begin
         ready = sel_onehot(grant);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         sel_q  <= CH0;
         ptr_q  <= CH0;
      end else if (load) begin
         data_q <= words[grant];
         sel_q  <= grant;
         ptr_q  <= sel_next(grant);
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = (state_q == ST_FULL);
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;
   assign state_dbg     = state_q;

endmodule

// File: doc/mux4_rr_tx.md
Name: mux4_rr_tx

Overview:
- 4-to-1 round-robin transmit multiplexer: the sending end of the 4-way select link.
- Four producer channels, each WIDTH bits with valid/ready handshake, are merged into one registered output stream.
- Each output word carries its source index as a 2-bit select (out_sel[1] = s1, out_sel[0] = s0), so a downstream 1:4 demux routes it back to output d0..d3.
- Sits between the four channel producers and the shared serial/parallel link.

Parameters:
- WIDTH, 8, data bits per channel word.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset, sampled on rising clk.
- in_valid  input  4  bit i: channel i presents a word.
- in_data  input  4*WIDTH  channel i word on bits [i*WIDTH +: WIDTH].
- in_ready  output  4  bit i: channel i word accepted this cycle (at most one bit high).
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered word.
- out_sel  output  2  registered source index of out_data; {s1,s0} for the receiving demux.
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset, synchronous on rising clk with rst=1: out_valid=0, out_data=0, out_sel=2'b00, round-robin pointer ptr=0. in_ready=4'b0000 while rst=1. Reset mid-transfer drops the held word without handshake.
- Handshakes:
  - A transfer on a channel occurs in a cycle where in_valid[i]=1 and in_ready[i]=1.
  - An output transfer occurs where out_valid=1 and out_ready=1.
- Load condition: load = (!out_valid || out_ready) && (|in_valid) && !rst.
- Grant: the first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with in_valid[i]=1. It is combinational from in_valid and ptr.
- in_ready = onehot(grant) when load=1, else 0. in_ready must not depend on in_data.
- On load, at the next edge:
  - out_data <= granted word, out_sel <= grant, out_valid <= 1.
  - ptr <= (grant+1) mod 4. The 2-bit increment wraps 3 to 0.
- On output transfer with no load: out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and load: the new word replaces the old one with no bubble, sustaining 1 word/cycle throughput.
- Stall (out_valid=1, out_ready=0): output is frozen, in_ready=0, ptr is unchanged.
- Latency: an accepted word appears on out_* on the cycle after acceptance.
- Fairness: with all four channels valid continuously, grants follow ptr order. No channel waits more than 3 output transfers after becoming valid.
- Producers must hold in_valid/in_data until accepted. The block never drops a word except on reset.
- State machine: 2 states.
  - EMPTY (out_valid=0) -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on stall or on drain with load.

Decomposition:
- Shared package/header:
  - NUM_CH=4
  - SEL_W=2
  - select encodings CH0=2'b00 .. CH3=2'b11, which must match the demux d0..d3 mapping.
- Sub-module rr_arbiter4 (ptr, req[3:0] -> grant index, any). Purely combinational; the output register and pointer stay in the top.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_sel=0. After release, the first grant is channel 0.
- Single channel: in_valid=4'b0100, data2=8'hA5, out_ready=1 -> in_ready=4'b0100 for one cycle; next cycle out_valid=1, out_data=8'hA5, out_sel=2'b10.
- Round-robin: all valid, data i = 8'h10+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,… back-to-back with no bubbles; out_data 8'h10,8'h11,8'h12,8'h13.
- Backpressure: out_ready=0 for 5 cycles with a word held -> out_data/out_sel stable and in_ready=0. Raising out_ready gives drain and reload in the same cycle.
- Wrap/skip: ptr=3, in_valid=4'b0011 -> grant 0, then 1, then (only ch0 valid) 0. ptr ends at 1.
- Loopback: connect to the 1:4 demux, each channel sending a counter -> each demux output d0..d3 sees only its own channel's words, in order.
